// File: rtl/timetag_pkg.sv
// Shared definitions for the event-tagging front end.
// Optional feature macro used by strobe_channel_cond: STROBE_COND_GLITCH_FILTER_EN.
package timetag_pkg;

    localparam int N_CHANNELS_DEFAULT = 4;
    localparam int DEADTIME_W_DEFAULT = 8;

    // Per-channel dead-time state
    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } ch_state_t;

endpackage

// File: rtl/strobe_channel_cond.sv
// One strobe channel: synchroniser, rising-edge detect, dead-time hold-off
// and sticky dropped-edge flag.
// Optional STROBE_COND_GLITCH_FILTER_EN: an edge needs sync_last high for two
// consecutive samples, adding one cycle of latency and rejecting 1-sample pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | count == 0, next detected edge is emitted on strobe_out
// HOLDOFF | count > 0, counting down; detected edges are dropped
module strobe_channel_cond
    import timetag_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEADTIME_W  = DEADTIME_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DEADTIME_W-1:0] deadtime,
    input  logic                  clear_drop,
    input  logic                  strobe_in,
    output logic                  strobe_out,
    output logic                  dropped,
    output logic                  busy
);

    localparam logic [DEADTIME_W-1:0] COUNT_ONE = {{(DEADTIME_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   level;
    logic                   prev_q;
    logic                   edge_det;
    logic                   drop_set;
    ch_state_t              state;
    logic [DEADTIME_W-1:0]  count;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, free-running regardless of enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
        end
    end

`ifdef STROBE_COND_GLITCH_FILTER_EN
    logic filt_q;

    // Extra stage so a level counts only after two consecutive high samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= sync_last;
        end
    end

    assign level = sync_last & filt_q;
`else
    assign level = sync_last;
`endif

    // Previous-level register; keeps tracking while disabled so a level that
    // is already high when enable rises never looks like a fresh edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign edge_det = level & ~prev_q;
    assign drop_set = enable & edge_det & (state == HOLDOFF);
    assign busy     = (state == HOLDOFF);

    // Dead-time state machine with registered strobe and sticky dropped flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            strobe_out <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            strobe_out <= 1'b0;

            // A new drop takes priority over a simultaneous clear
            if (drop_set) begin
                dropped <= 1'b1;
            end else if (clear_drop) begin
                dropped <= 1'b0;
            end

            if (!enable) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (edge_det) begin
                            strobe_out <= 1'b1;
                            if (deadtime != '0) begin
                                count <= deadtime;
                                state <= HOLDOFF;
                            end
                        end
                    end
                    HOLDOFF: begin
                        // Guarded decrement: the counter must never wrap
                        if (count != '0) begin
                            count <= count - COUNT_ONE;
                        end
                        if (count <= COUNT_ONE) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/strobe_conditioner.sv
// Strobe conditioner top: N_CHANNELS independent conditioning channels
// between the board strobe pins and the tagger strobe_channels input.
// Optional STROBE_COND_GLITCH_FILTER_EN adds a one-stage glitch filter per channel.
module strobe_conditioner
    import timetag_pkg::*;
#(
    parameter int N_CHANNELS  = N_CHANNELS_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DEADTIME_W  = DEADTIME_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DEADTIME_W-1:0] deadtime,
    input  logic                  clear_drop,
    input  logic [N_CHANNELS-1:0] strobe_in,
    output logic [N_CHANNELS-1:0] strobe_out,
    output logic [N_CHANNELS-1:0] dropped,
    output logic [N_CHANNELS-1:0] busy
);

    // SYNC_STAGES is meant to stay within 2..4
    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        strobe_channel_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEADTIME_W  (DEADTIME_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .deadtime   (deadtime),
            .clear_drop (clear_drop),
            .strobe_in  (strobe_in[i]),
            .strobe_out (strobe_out[i]),
            .dropped    (dropped[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_strobe_conditioner.sv
// Self-checking bench for strobe_conditioner: directed table, hand sequences
// for multi-cycle corners, and a randomized run against a time-based model.
// Honours STROBE_COND_GLITCH_FILTER_EN when the design is built with it.
module tb_strobe_conditioner;

    localparam int NC = 4;
    localparam int S  = 2;
    localparam int DW = 8;
`ifdef STROBE_COND_GLITCH_FILTER_EN
    localparam int LAT = S + 1;
`else
    localparam int LAT = S;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] deadtime = '0;
    logic          clear_drop = 1'b0;
    logic [NC-1:0] strobe_in = '0;
    logic [NC-1:0] strobe_out;
    logic [NC-1:0] dropped;
    logic [NC-1:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    strobe_conditioner #(
        .N_CHANNELS  (NC),
        .SYNC_STAGES (S),
        .DEADTIME_W  (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .deadtime   (deadtime),
        .clear_drop (clear_drop),
        .strobe_in  (strobe_in),
        .strobe_out (strobe_out),
        .dropped    (dropped),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: edges are derived from the history of input samples,
    // dead-time is tracked as the absolute clock index until which edges are held off.
    logic [NC-1:0] hist[$];
    int            t_now = 0;
    int            hold_until[NC];
    logic [NC-1:0] m_out = '0;
    logic [NC-1:0] m_drop = '0;
    logic [NC-1:0] m_busy = '0;
    bit            model_on = 1'b0;

    function automatic bit samp(int c, int back);
        return hist[hist.size() - 1 - back][c];
    endfunction

    function automatic bit det(int c);
`ifdef STROBE_COND_GLITCH_FILTER_EN
        return samp(c, S) & samp(c, S + 1) & ~samp(c, S + 2);
`else
        return samp(c, S) & ~samp(c, S + 1);
`endif
    endfunction

    always @(posedge clk) begin
        if (model_on) begin
            t_now++;
            if (!reset) begin
                hist = {};
                repeat (S + 4) hist.push_back('0);
                for (int c = 0; c < NC; c++) hold_until[c] = t_now;
                m_out  = '0;
                m_drop = '0;
                m_busy = '0;
            end else begin
                hist.push_back(strobe_in);
                if (hist.size() > 8) void'(hist.pop_front());
                for (int c = 0; c < NC; c++) begin
                    bit set_d;
                    set_d    = 1'b0;
                    m_out[c] = 1'b0;
                    if (!enable) begin
                        hold_until[c] = t_now;
                    end else if (det(c)) begin
                        if (t_now > hold_until[c]) begin
                            m_out[c]      = 1'b1;
                            hold_until[c] = t_now + int'(deadtime);
                        end else begin
                            set_d = 1'b1;
                        end
                    end
                    if (set_d) m_drop[c] = 1'b1;
                    else if (clear_drop) m_drop[c] = 1'b0;
                    m_busy[c] = (hold_until[c] > t_now);
                end
            end
        end
    end

    typedef struct {
        int ch;
        int d;
        int h1;
        int g;
        int h2;
        int exp_pulses;
        int exp_drop;
        int exp_busy;
    } row_t;

    row_t tbl[9];

    initial begin
        int pc;
        int bc;
        int tot;

        // ch, deadtime, high1, gap, high2, pulses, dropped, busy cycles
        tbl[0] = '{0, 0,   3, 1,  2, 2, 0, 0};
        tbl[1] = '{1, 0,   2, 1,  2, 2, 0, 0};
        tbl[2] = '{1, 5,   2, 1,  2, 1, 1, 5};
        tbl[3] = '{1, 5,   3, 3,  2, 2, 0, 10};
        tbl[4] = '{1, 5,   2, 3,  2, 1, 1, 5};
        tbl[5] = '{2, 3,   2, 2,  2, 2, 0, 6};
        tbl[6] = '{2, 3,   2, 1,  3, 1, 1, 3};
        tbl[7] = '{3, 255, 2, 10, 2, 1, 1, 255};
        tbl[8] = '{3, 1,   2, 1,  2, 2, 0, 2};

        // Reset state
        repeat (3) step();
        chk("reset_strobe_out", 32'(strobe_out), 32'(0));
        chk("reset_dropped", 32'(dropped), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        reset  = 1'b1;
        enable = 1'b1;
        step();
        step();

        // First-pulse latency: 3-sample pulse on ch0, deadtime 0
        for (int j = 0; j < LAT + 4; j++) begin
            strobe_in[0] = (j < 3);
            step();
            chk($sformatf("latency_j%0d", j), 32'(strobe_out[0]), 32'(j == LAT));
        end
        chk("latency_dropped", 32'(dropped), 32'(0));

        // Table of two-pulse episodes
        for (int r = 0; r < 9; r++) begin
            deadtime   = DW'(tbl[r].d);
            clear_drop = 1'b1;
            step();
            clear_drop = 1'b0;
            pc  = 0;
            bc  = 0;
            tot = tbl[r].h1 + tbl[r].g + tbl[r].h2 + tbl[r].d + LAT + 8;
            for (int j = 0; j < tot; j++) begin
                strobe_in[tbl[r].ch] = (j < tbl[r].h1) ||
                    (j >= tbl[r].h1 + tbl[r].g && j < tbl[r].h1 + tbl[r].g + tbl[r].h2);
                step();
                if (strobe_out[tbl[r].ch]) pc++;
                if (busy[tbl[r].ch]) bc++;
            end
            chk($sformatf("row%0d_pulses", r), 32'(pc), 32'(tbl[r].exp_pulses));
            chk($sformatf("row%0d_dropped", r), 32'(dropped[tbl[r].ch]), 32'(tbl[r].exp_drop));
            chk($sformatf("row%0d_busy_cycles", r), 32'(bc), 32'(tbl[r].exp_busy));
        end

        // Boundary: deadtime 3, edge at E+3 suppressed while clear_drop is also asserted
        deadtime   = 8'd3;
        clear_drop = 1'b1;
        step();
        for (int j = 0; j < LAT + 9; j++) begin
            strobe_in[2] = (j == 0 || j == 1 || j == 3 || j == 4);
            clear_drop   = (j == LAT + 3);
            step();
            if (j == LAT) chk("bnd_accept_E", 32'(strobe_out[2]), 32'(1));
            if (j == LAT + 3) begin
                chk("bnd_suppress_E3", 32'(strobe_out[2]), 32'(0));
                chk("bnd_set_wins", 32'(dropped[2]), 32'(1));
            end
        end
        clear_drop = 1'b1;
        step();
        clear_drop = 1'b0;
        chk("bnd_cleared", 32'(dropped[2]), 32'(0));

        // Disable during holdoff at count 7, edges while disabled, re-enable with input high
        deadtime = 8'd10;
        for (int j = 0; j < LAT + 5; j++) begin
            strobe_in[2] = (j < 2);
            step();
            if (j == LAT) chk("dis_accept", 32'(strobe_out[2]), 32'(1));
            if (j == LAT + 3) begin
                chk("dis_busy_before", 32'(busy[2]), 32'(1));
                enable = 1'b0;
            end
            if (j == LAT + 4) chk("dis_busy_cleared", 32'(busy[2]), 32'(0));
        end
        pc = 0;
        for (int j = 0; j < 12; j++) begin
            strobe_in[2] = (j < 2) || (j >= 4 && j < 6);
            step();
            if (strobe_out[2]) pc++;
        end
        chk("dis_no_pulse", 32'(pc), 32'(0));
        chk("dis_no_drop", 32'(dropped[2]), 32'(0));
        strobe_in[2] = 1'b1;
        repeat (5) step();
        enable = 1'b1;
        pc = 0;
        repeat (8) begin
            step();
            if (strobe_out[2]) pc++;
        end
        chk("reen_held_high", 32'(pc), 32'(0));
        pc = 0;
        for (int j = 0; j < LAT + 8; j++) begin
            strobe_in[2] = (j >= 3 && j < 5);
            step();
            if (strobe_out[2]) pc++;
        end
        chk("reen_new_edge", 32'(pc), 32'(1));
        repeat (14) step();

        // Short pulses on ch3 with deadtime 0
        deadtime   = 8'd0;
        clear_drop = 1'b1;
        step();
        clear_drop = 1'b0;
        pc = 0;
`ifdef STROBE_COND_GLITCH_FILTER_EN
        for (int j = 0; j < LAT + 5; j++) begin
            strobe_in[3] = (j == 0);
            step();
            if (strobe_out[3]) pc++;
        end
        chk("glitch_1cyc_pulses", 32'(pc), 32'(0));
        chk("glitch_1cyc_dropped", 32'(dropped[3]), 32'(0));
        pc = 0;
        for (int j = 0; j < LAT + 5; j++) begin
            strobe_in[3] = (j < 2);
            step();
            if (strobe_out[3]) pc++;
            if (j == LAT) chk("glitch_2cyc_latency", 32'(strobe_out[3]), 32'(1));
        end
        chk("glitch_2cyc_pulses", 32'(pc), 32'(1));
`else
        for (int j = 0; j < LAT + 6; j++) begin
            strobe_in[3] = (j == 0 || j == 2);
            step();
            if (strobe_out[3]) pc++;
        end
        chk("min_spacing_pulses", 32'(pc), 32'(2));
        chk("min_spacing_dropped", 32'(dropped[3]), 32'(0));
`endif

        // Simultaneous edges, then asynchronous reset mid-holdoff
        deadtime = 8'd2;
        for (int j = 0; j <= LAT; j++) begin
            strobe_in = (j < 2) ? 4'hF : 4'h0;
            step();
            if (j == LAT) begin
                chk("simul_strobe_out", 32'(strobe_out), 32'(4'hF));
                chk("simul_busy", 32'(busy), 32'(4'hF));
            end
        end
        strobe_in = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_strobe_out", 32'(strobe_out), 32'(0));
        chk("async_rst_busy", 32'(busy), 32'(0));
        chk("async_rst_dropped", 32'(dropped), 32'(0));
        repeat (3) step();
        reset = 1'b1;
        for (int j = 0; j <= LAT + 1; j++) begin
            strobe_in[1] = (j < 2);
            step();
            if (j == LAT) chk("post_rst_accept", 32'(strobe_out[1]), 32'(1));
        end
        repeat (4) step();

        // Randomized run against the model, starting from a fresh reset
        strobe_in = '0;
        reset     = 1'b0;
        model_on  = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if (enable) begin
                if ($urandom_range(0, 39) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) enable = 1'b1;
            end
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 2) == 0) strobe_in[c] = ~strobe_in[c];
            end
            if ($urandom_range(0, 14) == 0) deadtime = DW'($urandom_range(0, 6));
            clear_drop = ($urandom_range(0, 9) == 0);
            step();
            chk($sformatf("rand_n%0d", n), 32'({strobe_out, dropped, busy}),
                32'({m_out, m_drop, m_busy}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
